// File: rtl/rs_ms_driver.sv
// Drives the RS master-slave cell through one operation per request and
// reports the sampled Q with mismatch / illegal-state / bad-op flags.
module rs_ms_driver #(
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_op,
    output logic       R1,
    output logic       R2,
    output logic       R3,
    output logic       S1,
    output logic       S2,
    output logic       S3,
    output logic       PRE,
    output logic       CLR,
    output logic       ff_clk,
    input  logic       Q,
    input  logic       QBAR,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_q,
    output logic [2:0] rsp_err,
    output logic       cur_q,
    output logic       known
);

    localparam logic [2:0] OP_HOLD   = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_RESET  = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_PRESET = 3'b100;
    localparam logic [2:0] OP_CLEAR  = 3'b101;

    localparam logic [3:0] PULSE_LOAD  = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, SAMPLE, RESP} state_t;

    state_t     state, state_d;
    logic [3:0] cnt;
    logic       accept, bad_op, drive_rs;
    logic       r_d, s_d, pre_d, clr_d, exp_d, chk_d;
    logic       r_exc, s_exc, pre_exc, clr_exc, expected, chk_exp;

    assign req_ready = (state == IDLE) && !rst;
    assign accept    = req_valid && req_ready;

    // Excitation and expected value for the incoming op, from the current cell state.
    always_comb begin
        bad_op = 1'b0;
        r_d    = 1'b0;
        s_d    = 1'b0;
        pre_d  = 1'b0;
        clr_d  = 1'b0;
        exp_d  = cur_q;
        chk_d  = 1'b1;
        case (req_op)
            OP_HOLD:   chk_d = known;
            OP_SET:    begin s_d = 1'b1; exp_d = 1'b1; end
            OP_RESET:  begin r_d = 1'b1; exp_d = 1'b0; end
            OP_TOGGLE: begin
                if (!known) begin
                    bad_op = 1'b1;
                end else begin
                    s_d   = !cur_q;
                    r_d   = cur_q;
                    exp_d = !cur_q;
                end
            end
            OP_PRESET: begin pre_d = 1'b1; exp_d = 1'b1; end
            OP_CLEAR:  begin clr_d = 1'b1; exp_d = 1'b0; end
            default:   bad_op = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = bad_op ? RESP : SETUP;
            SETUP:   state_d = HIGH;
            HIGH:    if (cnt == 4'd0) state_d = LOW;
            LOW:     if (cnt == 4'd0) state_d = SAMPLE;
            SAMPLE:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Op latch and phase counter; only meaningful while an op is in flight.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept) begin
            r_exc    <= r_d;
            s_exc    <= s_d;
            pre_exc  <= pre_d;
            clr_exc  <= clr_d;
            expected <= exp_d;
            chk_exp  <= chk_d;
        end
        case (state)
            SETUP:   cnt <= PULSE_LOAD;
            HIGH:    cnt <= (cnt == 4'd0) ? SETTLE_LOAD : cnt - 4'd1;
            LOW:     cnt <= cnt - 4'd1;
            default: cnt <= cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_q   <= 1'b0;
            rsp_err <= 3'b000;
            cur_q   <= 1'b0;
            known   <= 1'b0;
        end else if (state == IDLE && accept && bad_op) begin
            rsp_q   <= cur_q;
            rsp_err <= 3'b100;
        end else if (state == SAMPLE) begin
            rsp_q <= Q;
            if (Q == QBAR) begin
                rsp_err <= 3'b010;
            end else begin
                cur_q   <= Q;
                known   <= 1'b1;
                rsp_err <= {2'b00, chk_exp && (Q != expected)};
            end
        end
    end

    // Pin outputs decode only registered state, so async ops never see ff_clk.
    assign drive_rs  = (state == SETUP) || (state == HIGH) || (state == LOW);
    assign R1        = drive_rs && r_exc;
    assign R2        = drive_rs && r_exc;
    assign R3        = drive_rs && r_exc;
    assign S1        = drive_rs && s_exc;
    assign S2        = drive_rs && s_exc;
    assign S3        = drive_rs && s_exc;
    assign PRE       = (state == HIGH) && pre_exc;
    assign CLR       = (state == HIGH) && clr_exc;
    assign ff_clk    = (state == HIGH) && !pre_exc && !clr_exc;
    assign rsp_valid = (state == RESP);

endmodule

// File: tb/tb_rs_ms_driver.sv
// Directed bench for rs_ms_driver with a behavioural cell and a timeline-based
// expectation model; a second instance covers a 3-cycle async pulse.
module tb_rs_ms_driver;
    localparam int P = 2;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0, rsp_ready = 1'b0;
    logic [2:0] req_op = 3'b000;
    logic       req_ready, R1, R2, R3, S1, S2, S3, PRE, CLR, ff_clk, Q, QBAR;
    logic       rsp_valid, rsp_q, cur_q, known;
    logic [2:0] rsp_err;

    rs_ms_driver dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .R1(R1), .R2(R2), .R3(R3), .S1(S1), .S2(S2), .S3(S3), .PRE(PRE), .CLR(CLR),
        .ff_clk(ff_clk), .Q(Q), .QBAR(QBAR), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_err(rsp_err), .cur_q(cur_q), .known(known)
    );

    logic       req_valid_b = 1'b0, rsp_ready_b = 1'b0;
    logic [2:0] req_op_b = 3'b000;
    logic       req_ready_b, R1_b, R2_b, R3_b, S1_b, S2_b, S3_b, PRE_b, CLR_b, ff_clk_b;
    logic       rsp_valid_b, rsp_q_b, cur_q_b, known_b;
    logic [2:0] rsp_err_b;
    logic       q_b = 1'b1;

    rs_ms_driver #(.PULSE_CYCLES(3), .SETTLE_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_op(req_op_b),
        .R1(R1_b), .R2(R2_b), .R3(R3_b), .S1(S1_b), .S2(S2_b), .S3(S3_b), .PRE(PRE_b), .CLR(CLR_b),
        .ff_clk(ff_clk_b), .Q(q_b), .QBAR(~q_b), .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_q(rsp_q_b), .rsp_err(rsp_err_b), .cur_q(cur_q_b), .known(known_b)
    );

    always @(posedge PRE_b or posedge CLR_b) begin
        if (PRE_b) q_b <= 1'b1;
        else       q_b <= 1'b0;
    end

    // Behavioural cell: master follows R/S while ff_clk is high, slave updates on the fall.
    logic cell_q = 1'b0;
    int   fault = 0;
    always @(negedge ff_clk or posedge PRE or posedge CLR) begin
        if (PRE)                                      cell_q <= 1'b1;
        else if (CLR)                                 cell_q <= 1'b0;
        else if ((S1 & S2 & S3) && !(R1 | R2 | R3))   cell_q <= 1'b1;
        else if ((R1 & R2 & R3) && !(S1 | S2 | S3))   cell_q <= 1'b0;
    end
    assign Q    = (fault == 0) ? cell_q  : 1'b1;
    assign QBAR = (fault == 0) ? ~cell_q : (fault == 1);

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: what the spec says the driver must show, per op.
    bit         mon_en = 1'b0, m_active = 1'b0, m_bad = 1'b0;
    bit         m_clocked, m_r, m_s, m_pre, m_clr;
    int         m_acc = 0;
    logic       m_cur = 1'b0, m_known = 1'b0, m_exp_q = 1'b0, m_nxt_cur, m_nxt_known;
    logic [2:0] m_exp_err = 3'b000;

    always @(negedge clk) begin
        if (mon_en) begin
            int  k;
            bit  e_r, e_s, e_pre, e_clr, e_ffc, e_rv, e_rdy, hi;
            k     = cyc - m_acc;
            e_r   = 0; e_s = 0; e_pre = 0; e_clr = 0; e_ffc = 0; e_rv = 0; e_rdy = 0;
            if (m_active && !m_bad) begin
                hi    = (k >= 1) && (k <= P);
                e_r   = m_r && (k <= P + S);
                e_s   = m_s && (k <= P + S);
                e_pre = m_pre && hi;
                e_clr = m_clr && hi;
                e_ffc = m_clocked && hi;
                e_rv  = (k >= P + S + 2);
            end else if (m_active) begin
                e_rv = 1;
            end else begin
                e_rdy = 1;
                chk("cur_q", int'(cur_q), int'(m_cur));
                chk("known", int'(known), int'(m_known));
            end
            chk("R", int'({R1, R2, R3}), e_r ? 7 : 0);
            chk("S", int'({S1, S2, S3}), e_s ? 7 : 0);
            chk("PRE", int'(PRE), int'(e_pre));
            chk("CLR", int'(CLR), int'(e_clr));
            chk("ff_clk", int'(ff_clk), int'(e_ffc));
            chk("rsp_valid", int'(rsp_valid), int'(e_rv));
            chk("req_ready", int'(req_ready), int'(e_rdy));
            if (e_rv) begin
                chk("rsp_q", int'(rsp_q), int'(m_exp_q));
                chk("rsp_err", int'(rsp_err), int'(m_exp_err));
            end
        end
    end

    task automatic do_op(input logic [2:0] op, input int bp, input logic lit_q,
                         input logic [2:0] lit_err, input int lit_lat);
        logic       e, q0;
        logic [2:0] err0;
        bit         do_chk;
        int         n;
        m_bad     = (op > 3'd5) || (op == 3'd3 && !m_known);
        m_clocked = (op <= 3'd3);
        m_pre     = (op == 3'd4);
        m_clr     = (op == 3'd5);
        m_s       = !m_bad && (op == 3'd1 || (op == 3'd3 && !m_cur));
        m_r       = !m_bad && (op == 3'd2 || (op == 3'd3 && m_cur));
        e         = (op == 3'd1 || op == 3'd4) ? 1'b1 :
                    (op == 3'd2 || op == 3'd5) ? 1'b0 :
                    (op == 3'd3) ? ~m_cur : m_cur;
        do_chk    = !(op == 3'd0 && !m_known);
        m_nxt_cur   = m_cur;
        m_nxt_known = m_known;
        if (m_bad) begin
            m_exp_q = m_cur; m_exp_err = 3'b100;
        end else if (fault == 1) begin
            m_exp_q = 1'b1; m_exp_err = 3'b010;
        end else if (fault == 2) begin
            m_exp_q = 1'b1; m_exp_err = (do_chk && e != 1'b1) ? 3'b001 : 3'b000;
            m_nxt_cur = 1'b1; m_nxt_known = 1'b1;
        end else begin
            m_exp_q = (op == 3'd0 && !m_known) ? cell_q : e;
            m_exp_err = 3'b000;
            m_nxt_cur = m_exp_q; m_nxt_known = 1'b1;
        end

        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        if (!req_ready) begin chk("accept_timeout", 0, 1); return; end
        req_op = op; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; m_acc = cyc; m_active = 1'b1;

        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin @(negedge clk); n++; end
        if (!rsp_valid) begin chk("rsp_timeout", 0, 1); m_active = 1'b0; return; end
        if (lit_lat >= 0) chk("latency", cyc - m_acc, lit_lat);
        q0 = rsp_q; err0 = rsp_err;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            chk("bp_rsp_q", int'(rsp_q), int'(q0));
            chk("bp_rsp_err", int'(rsp_err), int'(err0));
            chk("bp_req_ready", int'(req_ready), 0);
        end
        chk("lit_rsp_q", int'(rsp_q), int'(lit_q));
        chk("lit_rsp_err", int'(rsp_err), int'(lit_err));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; m_active = 1'b0;
        m_cur = m_nxt_cur; m_known = m_nxt_known;
    endtask

    task automatic op_b(input logic [2:0] op, input logic lit_q);
        int n, pulse, other, ffc, rs, k;
        n = 0; pulse = 0; other = 0; ffc = 0; rs = 0; k = 0;
        @(negedge clk);
        while (!req_ready_b && n < 20) begin @(negedge clk); n++; end
        req_op_b = op; req_valid_b = 1'b1;
        @(posedge clk); #1;
        req_valid_b = 1'b0;
        while (k < 30) begin
            @(negedge clk);
            if (rsp_valid_b) break;
            pulse += int'((op == 3'd4) ? PRE_b : CLR_b);
            other += int'((op == 3'd4) ? CLR_b : PRE_b);
            ffc   += int'(ff_clk_b);
            rs    += int'(R1_b | R2_b | R3_b | S1_b | S2_b | S3_b);
            k++;
        end
        chk("b_latency", k, 7);
        chk("b_pulse_cycles", pulse, 3);
        chk("b_other_pulse", other, 0);
        chk("b_ff_clk_cycles", ffc, 0);
        chk("b_rs_cycles", rs, 0);
        chk("b_rsp_q", int'(rsp_q_b), int'(lit_q));
        chk("b_rsp_err", int'(rsp_err_b), 0);
        rsp_ready_b = 1'b1;
        @(posedge clk); #1;
        rsp_ready_b = 1'b0;
        @(negedge clk);
        chk("b_cur_q", int'(cur_q_b), int'(lit_q));
        chk("b_known", int'(known_b), 1);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 0);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_pins", int'({R1, R2, R3, S1, S2, S3, PRE, CLR, ff_clk}), 0);
        chk("rst_rsp", int'({rsp_q, rsp_err}), 0);
        chk("rst_cur_known", int'({cur_q, known}), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", int'(req_ready), 1);
        mon_en = 1'b1;

        do_op(3'd3, 0, 1'b0, 3'b100, 0);   // toggle while unknown
        do_op(3'd0, 0, 1'b0, 3'b000, 6);   // hold while unknown
        do_op(3'd1, 0, 1'b1, 3'b000, 6);   // set
        do_op(3'd3, 0, 1'b0, 3'b000, 6);   // toggle -> 0 via R
        do_op(3'd3, 0, 1'b1, 3'b000, 6);   // toggle -> 1 via S
        do_op(3'd0, 5, 1'b1, 3'b000, 6);   // hold under backpressure
        do_op(3'd6, 0, 1'b1, 3'b100, 0);
        do_op(3'd7, 2, 1'b1, 3'b100, 0);
        do_op(3'd5, 0, 1'b0, 3'b000, 6);   // clear
        fault = 1;
        do_op(3'd2, 0, 1'b1, 3'b010, 6);   // Q==QBAR, cur_q stays 0
        fault = 2;
        do_op(3'd2, 0, 1'b1, 3'b001, 6);   // stuck at 1
        fault = 0;
        do_op(3'd4, 0, 1'b1, 3'b000, 6);   // preset

        mon_en = 1'b0;
        @(negedge clk);
        req_op = 3'd1; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_ff_clk_high", int'(ff_clk), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_pins", int'({R1, R2, R3, S1, S2, S3, PRE, CLR, ff_clk}), 0);
        chk("mid_rst_req_ready", int'(req_ready), 1);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_known", int'(known), 0);
        m_cur = 1'b0; m_known = 1'b0;
        mon_en = 1'b1;
        do_op(3'd1, 0, 1'b1, 3'b000, 6);

        op_b(3'd5, 1'b0);
        op_b(3'd4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
